// File: rtl/arith_nibble_seq.sv
// arith_nibble_seq: drives a 4-bit combinational arithmetic unit one nibble
// per clock, LSB first, chaining carries to build a 4*NIBBLES-bit operation.
// Optional feature macro: ARITH_SEQ_ZERO_FLAG_EN adds a registered 'zero'
// output flagging an all-zero final result.
module arith_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   ready,
    input  logic [4*NIBBLES-1:0]   op_x,
    input  logic [4*NIBBLES-1:0]   op_y,
    input  logic                   op_cin,
    input  logic [1:0]             op_s,
    input  logic                   op_a,
    input  logic                   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             au_x,
    output logic [3:0]             au_y,
    output logic                   au_cin,
    output logic [1:0]             au_s,
    output logic                   au_a,
    output logic                   au_b,
    input  logic [3:0]             au_d,
    input  logic                   au_cout
`ifdef ARITH_SEQ_ZERO_FLAG_EN
    ,
    output logic                   zero
`endif
);

    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   x_r;
    logic [W-1:0]   y_r;
    logic [1:0]     s_r;
    logic           a_r;
    logic           b_r;
    logic           carry_r;
    logic [2:0]     idx_r;
    logic [W-1:0]   result_r;
    logic           cout_r;
    logic [W-1:0]   result_next_s;
    logic [W-1:0]   x_shift_s;
    logic [W-1:0]   y_shift_s;
`ifdef ARITH_SEQ_ZERO_FLAG_EN
    logic           zero_r;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN until last nibble, DONE for one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Nibble select: shift the latched operands so the current nibble sits at bits [3:0].
    always_comb begin
        x_shift_s = x_r >> {idx_r, 2'b00};
        y_shift_s = y_r >> {idx_r, 2'b00};
    end

    // Merge the unit's result nibble into the result word at the current index.
    always_comb begin
        result_next_s = result_r;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_r == 3'(i)) begin
                result_next_s[4*i +: 4] = au_d;
            end else begin
                result_next_s[4*i +: 4] = result_r[4*i +: 4];
            end
        end
    end

    // Handshake flags and unit drive; the unit sees zeros outside RUN.
    always_comb begin
        ready  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        au_x   = 4'd0;
        au_y   = 4'd0;
        au_cin = 1'b0;
        au_s   = 2'd0;
        au_a   = 1'b0;
        au_b   = 1'b0;
        case (state_r)
            ST_IDLE: ready = 1'b1;
            ST_RUN: begin
                busy   = 1'b1;
                au_x   = x_shift_s[3:0];
                au_y   = y_shift_s[3:0];
                au_cin = carry_r;
                au_s   = s_r;
                au_a   = a_r;
                au_b   = b_r;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ready = 1'b0;
        endcase
    end

    // Datapath: latch request on acceptance, capture one nibble and carry per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r      <= {W{1'b0}};
            y_r      <= {W{1'b0}};
            s_r      <= 2'd0;
            a_r      <= 1'b0;
            b_r      <= 1'b0;
            carry_r  <= 1'b0;
            idx_r    <= 3'd0;
            result_r <= {W{1'b0}};
            cout_r   <= 1'b0;
`ifdef ARITH_SEQ_ZERO_FLAG_EN
            zero_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        x_r      <= op_x;
                        y_r      <= op_y;
                        s_r      <= op_s;
                        a_r      <= op_a;
                        b_r      <= op_b;
                        carry_r  <= op_cin;
                        idx_r    <= 3'd0;
                        result_r <= {W{1'b0}};
                        cout_r   <= 1'b0;
`ifdef ARITH_SEQ_ZERO_FLAG_EN
                        zero_r   <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    result_r <= result_next_s;
                    carry_r  <= au_cout;
                    if (idx_r == LAST_IDX) begin
                        // idx stays on the last nibble; it is re-zeroed at the next acceptance.
                        cout_r <= au_cout;
`ifdef ARITH_SEQ_ZERO_FLAG_EN
                        zero_r <= (result_next_s == {W{1'b0}});
`endif
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    assign result = result_r;
    assign cout   = cout_r;
`ifdef ARITH_SEQ_ZERO_FLAG_EN
    assign zero   = zero_r;
`endif

endmodule

// File: tb/tb_arith_nibble_seq.sv
// Scoreboard bench for arith_nibble_seq (NIBBLES=4) with an environment model
// of the 4-bit arithmetic unit and a wide-word reference model.
module tb_arith_nibble_seq;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           ready;
    logic [W-1:0]   op_x;
    logic [W-1:0]   op_y;
    logic           op_cin;
    logic [1:0]     op_s;
    logic           op_a;
    logic           op_b;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           cout;
    logic [3:0]     au_x;
    logic [3:0]     au_y;
    logic           au_cin;
    logic [1:0]     au_s;
    logic           au_a;
    logic           au_b;
    logic [3:0]     au_d;
    logic           au_cout;
`ifdef ARITH_SEQ_ZERO_FLAG_EN
    logic           zero;
`endif

    always #5 clk = ~clk;

    arith_nibble_seq #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .op_x(op_x), .op_y(op_y), .op_cin(op_cin), .op_s(op_s),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .cout(cout),
        .au_x(au_x), .au_y(au_y), .au_cin(au_cin), .au_s(au_s),
        .au_a(au_a), .au_b(au_b), .au_d(au_d), .au_cout(au_cout)
`ifdef ARITH_SEQ_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    int pass_n  = 0;
    int total_n = 0;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // 4-bit arithmetic unit (environment): optional operand inversion, then op.
    function automatic logic [4:0] unit4(logic [3:0] x, logic [3:0] y, logic cin,
                                         logic [1:0] s, logic a, logic b);
        logic [3:0] xx, yy;
        logic [4:0] r;
        xx = a ? ~x : x;
        yy = b ? ~y : y;
        case (s)
            2'b00:   r = {1'b0, xx} + {1'b0, yy} + {4'd0, cin};
            2'b01:   r = {1'b0, xx} + {1'b0, ~yy} + {4'd0, cin};
            2'b10:   r = {cin, xx ^ yy};
            default: r = {cin, xx & yy};
        endcase
        return r;
    endfunction

    always_comb begin
        {au_cout, au_d} = unit4(au_x, au_y, au_cin, au_s, au_a, au_b);
    end

    // Wide reference: same operation applied to the low nb nibbles as one word.
    function automatic logic [32:0] model(logic [31:0] x, logic [31:0] y, logic cin,
                                          logic [1:0] s, logic a, logic b, int nb);
        int w;
        logic [32:0] mask, xx, yy, r;
        w    = 4 * nb;
        mask = (33'd1 << w) - 33'd1;
        xx   = {1'b0, (a ? ~x : x)} & mask;
        yy   = {1'b0, (b ? ~y : y)} & mask;
        case (s)
            2'b00:   r = xx + yy + 33'(cin);
            2'b01:   r = xx + ((~yy) & mask) + 33'(cin);
            2'b10:   r = (xx ^ yy) | (33'(cin) << w);
            default: r = (xx & yy) | (33'(cin) << w);
        endcase
        return {r[w], r[31:0] & mask[31:0]};
    endfunction

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [1:0]   s;
        logic         a;
        logic         b;
        logic [W-1:0] res;
        logic         co;
        logic [7:0]   cinv;
        int           edge_n;
    } exp_t;

    exp_t sb_q[$];
    int   edge_n = 0;

    // Acceptance watcher: push the expected outcome of every accepted request.
    always @(posedge clk) begin
        exp_t e;
        logic [32:0] m;
        edge_n = edge_n + 1;
        if (!rst && start && ready) begin
            e.x = op_x; e.y = op_y; e.s = op_s; e.a = op_a; e.b = op_b;
            m = model(32'(op_x), 32'(op_y), op_cin, op_s, op_a, op_b, N);
            e.res  = m[W-1:0];
            e.co   = m[32];
            e.cinv = 8'd0;
            for (int i = 0; i < N; i++) begin
                m = model(32'(op_x), 32'(op_y), op_cin, op_s, op_a, op_b, i);
                e.cinv[i] = m[32];
            end
            e.edge_n = edge_n + N;
            sb_q.push_back(e);
        end
    end

    int         n_run = 0;
    logic [7:0] cin_seen = 8'd0;
    logic       feed_ok = 1'b1;
    int         done_cnt = 0;
    logic       ready_pending = 1'b0;

    // Monitor: observe the unit feed during RUN and compare on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] tx, ty;
        if (rst) begin
            n_run = 0; cin_seen = 8'd0; feed_ok = 1'b1; ready_pending = 1'b0;
        end else begin
            if (ready_pending) begin
                check("ready_after_done", 64'(ready), 64'd1);
                ready_pending = 1'b0;
            end
            if (busy && !done) begin
                if (sb_q.size() > 0) begin
                    e  = sb_q[0];
                    tx = e.x >> (4 * n_run);
                    ty = e.y >> (4 * n_run);
                    if (au_x !== tx[3:0] || au_y !== ty[3:0] || au_s !== e.s ||
                        au_a !== e.a || au_b !== e.b) feed_ok = 1'b0;
                end
                if (n_run < 8) cin_seen[n_run] = au_cin;
                n_run++;
            end
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    total_n++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request");
                end else begin
                    e = sb_q.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("cout", 64'(cout), 64'(e.co));
                    check("done_edge", 64'(edge_n), 64'(e.edge_n));
                    check("carry_chain", 64'(cin_seen), 64'(e.cinv));
                    check("run_cycles", 64'(n_run), 64'(N));
                    check("feed", 64'(feed_ok), 64'd1);
`ifdef ARITH_SEQ_ZERO_FLAG_EN
                    check("zero", 64'(zero), 64'(e.res == {W{1'b0}}));
`endif
                end
                n_run = 0; cin_seen = 8'd0; feed_ok = 1'b1; ready_pending = 1'b1;
            end
            if (ready || done) begin
                check("au_idle_zero", 64'({au_x, au_y, au_cin, au_s, au_a, au_b}), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                         input logic [1:0] s, input logic a, input logic b);
        int t = 0;
        while (!ready && t < 100) begin tick(); t++; end
        if (!ready) begin
            total_n++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
        end
        op_x = x; op_y = y; op_cin = cin; op_s = s; op_a = a; op_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_x = W'($urandom); op_y = W'($urandom); op_cin = 1'($urandom);
        op_s = 2'($urandom); op_a = 1'($urandom); op_b = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb_q.size() != 0 || !ready) && t < 200) begin tick(); t++; end
        if (sb_q.size() != 0 || !ready) begin
            total_n++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; op_x = '0; op_y = '0; op_cin = 1'b0;
        op_s = 2'd0; op_a = 1'b0; op_b = 1'b0;
        repeat (3) tick();
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'({cout, result}), 64'd0);
        check("rst_au", 64'({au_x, au_y, au_cin, au_s, au_a, au_b}), 64'd0);
        rst = 1'b0;
        tick();

        // Directed cases.
        do_op(16'h1234, 16'h0FFF, 1'b0, 2'b00, 1'b0, 1'b0); drain();
        check("dir_add_result", 64'(result), 64'h2233);
        do_op(16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0); drain();
        check("dir_wrap_result", 64'({cout, result}), 64'h10000);
        do_op(16'h0009, 16'h0003, 1'b1, 2'b00, 1'b0, 1'b0); drain();
        check("dir_cin_result", 64'({cout, result}), 64'h0000D);

        // start held high across two operations, operands changing every cycle.
        d0 = done_cnt;
        op_x = W'($urandom); op_y = W'($urandom); op_cin = 1'($urandom);
        op_s = 2'($urandom); op_a = 1'($urandom); op_b = 1'($urandom);
        start = 1'b1;
        for (int i = 0; i < 2 * (N + 2); i++) begin
            tick();
            op_x = W'($urandom); op_y = W'($urandom); op_cin = 1'($urandom);
            op_s = 2'($urandom); op_a = 1'($urandom); op_b = 1'($urandom);
        end
        start = 1'b0;
        drain();
        check("held_start_dones", 64'(done_cnt - d0), 64'd2);

        // Reset during RUN at idx 2.
        do_op(16'h1234, 16'h0FFF, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_result", 64'({cout, result}), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        sb_q.delete();
        rst = 1'b0;
        d0 = done_cnt;
        repeat (N + 2) tick();
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        do_op(16'h1234, 16'h0FFF, 1'b0, 2'b00, 1'b0, 1'b0); drain();
        check("post_rst_result", 64'(result), 64'h2233);

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom));
            if (($urandom % 2) == 0) drain();
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule

// File: doc/arith_nibble_seq.md
# arith_nibble_seq

Multi-cycle sequencer that drives the 4-bit arithmetic unit (x, y, cin, s, a, b → d, cout) one nibble per clock to perform wide operations. It latches a wide request, feeds nibbles LSB-first, chains each nibble's cout into the next nibble's cin, and assembles the wide result. It sits between a requesting master (start/ready handshake) and a single combinational arithmetic unit instance.

## Interface

Parameters:
- NIBBLES, 4, operand width in nibbles; legal range 1..8; data width W = 4*NIBBLES

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request strobe, sampled only in IDLE
- ready  out  1  high in IDLE; request accepted when start && ready
- op_x  in  W  operand x
- op_y  in  W  operand y
- op_cin  in  1  carry-in for nibble 0
- op_s  in  2  unit select code, forwarded unchanged to every nibble
- op_a  in  1  unit mode bit a, forwarded unchanged
- op_b  in  1  unit mode bit b, forwarded unchanged
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse in DONE
- result  out  W  assembled result, held until next accepted start
- cout  out  1  carry out of the last nibble, held with result
- au_x, au_y  out  4  current nibble to unit
- au_cin  out  1  carry to unit
- au_s  out  2  select to unit
- au_a, au_b  out  1  mode bits to unit
- au_d  in  4  unit result nibble
- au_cout  in  1  unit carry out

## Operation

- States: IDLE, RUN, DONE.
- IDLE: ready=1; au_* driven 0. On start: latch op_x, op_y, op_s, op_a, op_b; carry register ← op_cin; idx ← 0; clear result and cout; go RUN.
- RUN: au_x = x_reg[4*idx+:4], au_y = y_reg[4*idx+:4], au_cin = carry register, au_s/au_a/au_b = latched values. Each edge: result[4*idx+:4] ← au_d; carry ← au_cout; idx ← idx+1. When idx == NIBBLES-1, cout ← au_cout and go DONE.
- DONE: done=1 for exactly one cycle; au_* driven 0; next edge → IDLE.
- start while busy is ignored; no queuing. Operand inputs may change freely after acceptance.
- Nibble 0 uses op_cin; nibbles 1..NIBBLES-1 use the previous nibble's au_cout, never op_cin.
- idx is 3 bits; never exceeds NIBBLES-1.
- NIBBLES=1: RUN lasts one cycle.
- Reset in any state: state IDLE, idx 0, carry 0, result 0, cout 0, done 0, busy 0; an interrupted operation produces no done pulse.
- Reset values: ready=1, busy=0, done=0, result=0, cout=0, au_* = 0.

## Timing

- Request accepted at edge k (start && ready).
- Nibble i presented during cycle after edge k+i; captured at edge k+i+1.
- DONE entered at edge k+NIBBLES; done high for that cycle; result/cout valid from that cycle onward.
- IDLE re-entered at edge k+NIBBLES+1; next acceptance no earlier than that edge, so throughput is one operation per NIBBLES+2 cycles.
- Unit is combinational; au_* come from registers plus the idx mux, so the unit path is contained in one cycle.

## Configuration

- ARITH_SEQ_ZERO_FLAG_EN defined: extra output port zero (1 bit), registered with cout at the edge entering DONE; zero=1 iff final result == 0; cleared by reset and on acceptance.
- Not defined: no zero port, no zero-detect logic.

## Test plan

- NIBBLES=4, s=00 (add), x=0x1234, y=0x0FFF, cin=0 → result 0x2233, cout 0, done exactly at edge k+4, ready again at k+5.
- x=0xFFFF, y=0x0001, cin=0 → result 0x0000, cout 1; au_cin = 0,1,1,1 on nibbles 0..3 (ripple check).
- x=0x0009, y=0x0003, cin=1 → au_cin=1 on nibble 0 only, result 0x000D, cout 0.
- start held high continuously across two operations → exactly one done per NIBBLES+2 cycles; second operation's latched operands are the values present at its acceptance edge.
- rst asserted during RUN idx=2 → next cycle busy 0, ready 1, result 0, no done; subsequent 0x1234+0x0FFF completes with 0x2233.
- With ARITH_SEQ_ZERO_FLAG_EN: 0xFFFF+0x0001 → zero=1, cout=1; 0x1234+0x0FFF → zero=0.
